// File: rtl/dfr_readout_engine.sv
// DFR multi-output readout layer: Z[r][c] = sum_k X[r][k] * W[c][k].
// Streams X/W from BRAMs with a tagged read pipeline, scales the accumulator
// by FRAC_BITS, saturates into DATA_WIDTH and writes one Z element per pass.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; addresses hold their last value
// S_FETCH | issuing x/y addresses for k = 0..K-1, accumulating returns
// S_DRAIN | no new addresses, collecting the last MEM_LATENCY returns
// S_WRITE | z_wen high for one element, step to next column/row
// S_DONE  | one-cycle done pulse, back to idle
module dfr_readout_engine #(
    parameter int ADDR_WIDTH        = 17,
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_VIRTUAL_NODES = 100,
    parameter int MAX_OUTPUTS       = 4,
    parameter int MEM_LATENCY       = 1,
    parameter int ACC_WIDTH         = 64,
    parameter int FRAC_BITS         = 16,
    localparam int OW               = $clog2(MAX_OUTPUTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_rows,
    input  logic [OW-1:0]         num_outputs,
    output logic                  busy,
    output logic                  done,
    output logic                  sat_flag,
    output logic [ADDR_WIDTH-1:0] x_addr,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic [ADDR_WIDTH-1:0] y_addr,
    input  logic [DATA_WIDTH-1:0] y_data,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic [DATA_WIDTH-1:0] z_data,
    output logic                  z_wen
);

    localparam int CNT_MAX = (NUM_VIRTUAL_NODES > MEM_LATENCY) ? NUM_VIRTUAL_NODES : MEM_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]         K_LAST    = CW'(NUM_VIRTUAL_NODES - 1);
    localparam logic [CW-1:0]         L_LAST    = CW'(MEM_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] K_REWIND  = ADDR_WIDTH'(NUM_VIRTUAL_NODES - 1);
    localparam logic [OW-1:0]         C_MAX     = OW'(MAX_OUTPUTS);
    localparam logic [DATA_WIDTH-1:0] Z_POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] Z_NEG_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                        state;
    logic [CW-1:0]                 cnt;
    logic [ADDR_WIDTH-1:0]         rows_q;
    logic [OW-1:0]                 cols_q;
    logic [ADDR_WIDTH-1:0]         r;
    logic [OW-1:0]                 c;
    logic [ADDR_WIDTH-1:0]         z_idx;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [MEM_LATENCY-1:0]        vpipe;

    logic [OW-1:0]                 cols_in;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   acc_shift;
    logic [ACC_WIDTH-DATA_WIDTH:0] acc_hi;
    logic                          ovf;
    logic [DATA_WIDTH-1:0]         z_sat;

    // Requested column count clamped to what the engine supports.
    assign cols_in = (num_outputs > C_MAX) ? C_MAX : num_outputs;

    // Datapath: full signed product, tagged accumulate, scale and saturate.
    // Overflow is detected when the bits above the Z sign bit are not all copies of it.
    assign prod      = $signed(x_data) * $signed(y_data);
    assign acc_next  = vpipe[MEM_LATENCY-1] ? (acc + ACC_WIDTH'(prod)) : acc;
    assign acc_shift = acc_next >>> FRAC_BITS;
    assign acc_hi    = acc_shift[ACC_WIDTH-1:DATA_WIDTH-1];
    assign ovf       = !((&acc_hi) || !(|acc_hi));
    assign z_sat     = ovf ? (acc_shift[ACC_WIDTH-1] ? Z_NEG_MIN : Z_POS_MAX)
                           : acc_shift[DATA_WIDTH-1:0];

    // Valid tags follow each issued address so returns line up with BRAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= (state == S_FETCH);
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    // Sequencing FSM with registered outputs; the final return is folded in
    // on the DRAIN->WRITE edge so z_data is valid exactly while in WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            r        <= '0;
            c        <= '0;
            z_idx    <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
            x_addr   <= '0;
            y_addr   <= '0;
            z_addr   <= '0;
            z_data   <= '0;
            z_wen    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rows_q   <= num_rows;
                        cols_q   <= cols_in;
                        sat_flag <= 1'b0;
                        r        <= '0;
                        c        <= '0;
                        z_idx    <= '0;
                        acc      <= '0;
                        if (num_rows == '0 || cols_in == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                            busy   <= 1'b1;
                            x_addr <= '0;
                            y_addr <= '0;
                            cnt    <= K_LAST;
                        end
                    end
                end
                S_FETCH: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        state <= S_DRAIN;
                        cnt   <= L_LAST;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        x_addr <= x_addr + 1'b1;
                        y_addr <= y_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        state  <= S_WRITE;
                        z_wen  <= 1'b1;
                        z_addr <= z_idx;
                        z_data <= z_sat;
                        if (ovf) begin
                            sat_flag <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    z_wen <= 1'b0;
                    acc   <= '0;
                    z_idx <= z_idx + 1'b1;
                    cnt   <= K_LAST;
                    // Addresses sit at base+K-1 here: +1 steps to the next base,
                    // -(K-1) rewinds to the current base.
                    if (c == cols_q - 1'b1) begin
                        c <= '0;
                        if (r == rows_q - 1'b1) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                            r      <= r + 1'b1;
                            x_addr <= x_addr + 1'b1;
                            y_addr <= '0;
                        end
                    end else begin
                        state  <= S_FETCH;
                        c      <= c + 1'b1;
                        x_addr <= x_addr - K_REWIND;
                        y_addr <= y_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dfr_readout_engine.sv
// Directed bench for dfr_readout_engine. Three instances with K=4, C_max=4:
// [0] FRAC_BITS=0, MEM_LATENCY=1; [1] FRAC_BITS=16 (72-bit accumulator so the
// large products saturate rather than wrap); [2] MEM_LATENCY=3.
// Cycle counts include the start cycle and the done cycle.
module tb_dfr_readout_engine;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int OW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] num_rows    = '0;
    logic [OW-1:0] num_outputs = '0;
    logic [2:0]    start_v     = '0;
    logic [2:0]    busy_v, done_v, sat_v, zw_v;
    logic [AW-1:0] xa [3];
    logic [AW-1:0] ya [3];
    logic [AW-1:0] za [3];
    logic [DW-1:0] xd [3];
    logic [DW-1:0] yd [3];
    logic [DW-1:0] zd [3];

    logic [DW-1:0] x_mem [16];
    logic [DW-1:0] w_mem [16];
    logic [DW-1:0] xp [2];
    logic [DW-1:0] yp [2];

    logic [31:0] wq_a [$];
    logic [31:0] wq_d [$];
    logic [31:0] exp_a [$];
    logic [31:0] exp_d [$];
    int cur = 0;
    int n_chk = 0;
    int n_pass = 0;
    int cyc;

    dfr_readout_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_VIRTUAL_NODES(4),
        .MAX_OUTPUTS(4), .MEM_LATENCY(1), .ACC_WIDTH(64), .FRAC_BITS(0)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .num_rows(num_rows), .num_outputs(num_outputs),
        .busy(busy_v[0]), .done(done_v[0]), .sat_flag(sat_v[0]),
        .x_addr(xa[0]), .x_data(xd[0]), .y_addr(ya[0]), .y_data(yd[0]),
        .z_addr(za[0]), .z_data(zd[0]), .z_wen(zw_v[0]));

    dfr_readout_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_VIRTUAL_NODES(4),
        .MAX_OUTPUTS(4), .MEM_LATENCY(1), .ACC_WIDTH(72), .FRAC_BITS(16)) u_f (
        .clk(clk), .rst(rst), .start(start_v[1]), .num_rows(num_rows), .num_outputs(num_outputs),
        .busy(busy_v[1]), .done(done_v[1]), .sat_flag(sat_v[1]),
        .x_addr(xa[1]), .x_data(xd[1]), .y_addr(ya[1]), .y_data(yd[1]),
        .z_addr(za[1]), .z_data(zd[1]), .z_wen(zw_v[1]));

    dfr_readout_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_VIRTUAL_NODES(4),
        .MAX_OUTPUTS(4), .MEM_LATENCY(3), .ACC_WIDTH(64), .FRAC_BITS(0)) u_l (
        .clk(clk), .rst(rst), .start(start_v[2]), .num_rows(num_rows), .num_outputs(num_outputs),
        .busy(busy_v[2]), .done(done_v[2]), .sat_flag(sat_v[2]),
        .x_addr(xa[2]), .x_data(xd[2]), .y_addr(ya[2]), .y_data(yd[2]),
        .z_addr(za[2]), .z_data(zd[2]), .z_wen(zw_v[2]));

    // BRAM models: one-cycle reads for [0],[1]; three-cycle read for [2].
    always @(posedge clk) begin
        xd[0] <= x_mem[xa[0][3:0]];
        yd[0] <= w_mem[ya[0][3:0]];
        xd[1] <= x_mem[xa[1][3:0]];
        yd[1] <= w_mem[ya[1][3:0]];
        xp[0] <= x_mem[xa[2][3:0]];
        yp[0] <= w_mem[ya[2][3:0]];
        xp[1] <= xp[0];
        yp[1] <= yp[0];
        xd[2] <= xp[1];
        yd[2] <= yp[1];
    end

    // Capture Z writes of the instance currently under test.
    always @(negedge clk) begin
        if (!rst && zw_v[cur]) begin
            wq_a.push_back(32'(za[cur]));
            wq_d.push_back(zd[cur]);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            x_mem[i] = '0;
            w_mem[i] = '0;
        end
    endtask

    task automatic set_x(input int row, input logic [31:0] a, b, c, d);
        x_mem[row*4]   = a;
        x_mem[row*4+1] = b;
        x_mem[row*4+2] = c;
        x_mem[row*4+3] = d;
    endtask

    task automatic set_w(input int col, input logic [31:0] a, b, c, d);
        w_mem[col*4]   = a;
        w_mem[col*4+1] = b;
        w_mem[col*4+2] = c;
        w_mem[col*4+3] = d;
    endtask

    // One run: start pulse, wait for done (bounded), check busy behaviour.
    task automatic run(input int sel, input int rows, input int cols, input bit disturb,
                       output int cycles);
        int n;
        wq_a.delete();
        wq_d.delete();
        cur         = sel;
        num_rows    = AW'(rows);
        num_outputs = OW'(cols);
        @(negedge clk);
        start_v[sel] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start_v[sel] = 1'b0;
            n++;
            if (n == 1)
                check("busy_after_start", busy_v[sel], (rows != 0 && cols != 0));
            if (disturb && n == 10) begin
                start_v[sel] = 1'b1;
                num_rows     = AW'(1);
                num_outputs  = OW'(1);
            end
        end while (!done_v[sel] && n < 1000);
        check("done_seen", done_v[sel], 1'b1);
        check("busy_at_done", busy_v[sel], 1'b0);
        cycles = n + 1;
        @(negedge clk);
        check("done_one_cycle", done_v[sel], 1'b0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, wq_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < wq_a.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wq_a[i], exp_a[i]);
            check($sformatf("%s_data%0d", tag, i), wq_d[i], exp_d[i]);
        end
    endtask

    initial begin
        bit got_done;
        int n;
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_done", done_v[0], 1'b0);
        check("rst_zwen", zw_v[0], 1'b0);
        check("rst_sat", sat_v[0], 1'b0);
        check("rst_xaddr", xa[0], 0);
        check("rst_zaddr", za[0], 0);
        check("rst_zdata", zd[0], 0);

        // Single element: 1+2+3+4 = 10.
        clear_mem();
        set_x(0, 1, 2, 3, 4);
        set_w(0, 1, 1, 1, 1);
        run(0, 1, 1, 0, cyc);
        check("t1_cycles", cyc, 8);
        exp_a = '{0};
        exp_d = '{10};
        check_writes("t1");
        check("t1_sat", sat_v[0], 1'b0);

        // 2x3 with a start pulse and input changes mid-run that must be ignored.
        clear_mem();
        set_x(0, 1, 0, 0, 0);
        set_x(1, 0, 1, 0, 0);
        for (int c = 0; c < 4; c++) set_w(c, c+1, c+2, c+3, c+4);
        run(0, 2, 3, 1, cyc);
        check("t2_cycles", cyc, 38);
        exp_a = '{0, 1, 2, 3, 4, 5};
        exp_d = '{1, 2, 3, 2, 3, 4};
        check_writes("t2");

        // Same job through the three-cycle BRAM: 8 cycles per element.
        run(2, 2, 3, 0, cyc);
        check("t5_cycles", cyc, 50);
        check_writes("t5");

        // Degenerate sizes and column clamp.
        run(0, 0, 3, 0, cyc);
        check("r0_cycles", cyc, 2);
        check("r0_writes", wq_a.size(), 0);
        run(0, 2, 0, 0, cyc);
        check("c0_cycles", cyc, 2);
        check("c0_writes", wq_a.size(), 0);
        run(0, 1, 7, 0, cyc);
        check("c7_cycles", cyc, 26);
        exp_a = '{0, 1, 2, 3};
        exp_d = '{1, 2, 3, 4};
        check_writes("c7");

        // Saturation boundary at FRAC_BITS=0: exactly max passes, max+1 clamps.
        clear_mem();
        set_x(0, 32'h7FFF_FFFF, 0, 0, 0);
        set_w(0, 1, 1, 1, 1);
        run(0, 1, 1, 0, cyc);
        exp_a = '{0};
        exp_d = '{32'h7FFF_FFFF};
        check_writes("edge_max");
        check("edge_max_sat", sat_v[0], 1'b0);
        set_x(0, 32'h7FFF_FFFF, 1, 0, 0);
        run(0, 1, 1, 0, cyc);
        check_writes("edge_ovf");
        check("edge_ovf_sat", sat_v[0], 1'b1);

        // FRAC_BITS=16: large positive/negative saturate, sticky flag cleared by next start.
        clear_mem();
        set_x(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        set_w(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run(1, 1, 1, 0, cyc);
        exp_a = '{0};
        exp_d = '{32'h7FFF_FFFF};
        check_writes("f_pos");
        check("f_pos_sat", sat_v[1], 1'b1);
        set_x(0, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001);
        run(1, 1, 1, 0, cyc);
        exp_d = '{32'h8000_0000};
        check_writes("f_neg");
        check("f_neg_sat", sat_v[1], 1'b1);
        clear_mem();
        set_x(0, 32'hFFFF_FFFD, 0, 0, 0);
        set_w(0, 32'h0001_0000, 0, 0, 0);
        run(1, 1, 1, 0, cyc);
        exp_d = '{32'hFFFF_FFFD};
        check_writes("f_m3");
        check("f_sat_cleared", sat_v[1], 1'b0);
        set_x(0, 32'hFFFF_FFFF, 0, 0, 0);
        set_w(0, 1, 0, 0, 0);
        run(1, 1, 1, 0, cyc);
        exp_d = '{32'hFFFF_FFFF};
        check_writes("f_m1");

        // Reset mid-FETCH: busy and z_wen drop at once, no done afterwards.
        clear_mem();
        set_x(0, 1, 2, 3, 4);
        set_w(0, 1, 1, 1, 1);
        cur         = 0;
        num_rows    = AW'(2);
        num_outputs = OW'(3);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", busy_v[0], 1'b1);
        rst = 1'b1;
        #1;
        check("rst_fetch_busy", busy_v[0], 1'b0);
        check("rst_fetch_zwen", zw_v[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        got_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done_v[0]) got_done = 1'b1;
        end
        check("rst_no_done", got_done, 1'b0);

        // Reset while z_wen is high drops it asynchronously.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while (!zw_v[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("zwen_seen", zw_v[0], 1'b1);
        rst = 1'b1;
        #1;
        check("rst_write_zwen", zw_v[0], 1'b0);
        check("rst_write_busy", busy_v[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Fresh run after reset behaves normally.
        run(0, 1, 1, 0, cyc);
        check("post_rst_cycles", cyc, 8);
        exp_a = '{0};
        exp_d = '{10};
        check_writes("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
